// File: rtl/mac_tile_sequencer_if.sv
// Command / operand / MAC-array / writeback signal bundle for mac_tile_sequencer.
// master = command decoder / operand buffer / writeback side, slave = sequencer.
interface mac_tile_sequencer_if #(
  parameter int K_W     = 16,
  parameter int STALL_W = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [K_W-1:0]     cmd_k_len;
  logic               cmd_data_type;
  logic               abort;
  logic               opd_valid;
  logic               opd_ready;
  logic               mac_enable;
  logic               mac_clear_acc;
  logic               mac_data_type;
  logic               res_valid;
  logic               res_ready;
  logic               busy;
  logic               aborted;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output cmd_valid, cmd_k_len, cmd_data_type, abort, opd_valid, res_ready,
    input  cmd_ready, opd_ready, mac_enable, mac_clear_acc, mac_data_type,
           res_valid, busy, aborted, stall_cnt
  );

  modport slave (
    input  cmd_valid, cmd_k_len, cmd_data_type, abort, opd_valid, res_ready,
    output cmd_ready, opd_ready, mac_enable, mac_clear_acc, mac_data_type,
           res_valid, busy, aborted, stall_cnt
  );
endinterface

// File: rtl/mac_tile_sequencer.sv
// Sequences one output tile on the 8x8 MAC array: clear, K operand beats,
// pipeline drain, then a result-valid handshake to writeback.
module mac_tile_sequencer #(
  parameter int K_W          = 16,
  parameter int DRAIN_CYCLES = 5,
  parameter int STALL_W      = 16
) (
  input logic                clk,
  input logic                rst_n,
  mac_tile_sequencer_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;

  state_t             state;
  logic [K_W-1:0]     k_rem;
  logic [DW-1:0]      drain_cnt;
  logic               dtype_q;
  logic               aborted_q;
  logic [STALL_W-1:0] stall_q;

  // Tile FSM plus its counters; abort overrides every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_rem     <= '0;
      drain_cnt <= '0;
      dtype_q   <= 1'b0;
      aborted_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      aborted_q <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state     <= IDLE;
        aborted_q <= 1'b1;
        // A beat offered alongside abort is still taken off the operand bus.
        if (state == ACCUM && bus.opd_valid && k_rem != '0)
          k_rem <= k_rem - 1'b1;
      end else begin
        case (state)
          IDLE: if (bus.cmd_valid) begin
            k_rem   <= bus.cmd_k_len;
            dtype_q <= bus.cmd_data_type;
            stall_q <= '0;
            state   <= CLEAR;
          end
          CLEAR: if (k_rem != '0) state <= ACCUM;
                 else begin
                   state     <= DRAIN;
                   drain_cnt <= DRAIN_LOAD;
                 end
          ACCUM: if (bus.opd_valid) begin
            if (k_rem != '0) k_rem <= k_rem - 1'b1;
            if (k_rem <= K_W'(1)) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end else if (stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
          end
          DRAIN: if (drain_cnt == '0) state <= DONE;
                 else drain_cnt <= drain_cnt - 1'b1;
          DONE:  if (bus.res_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Handshake / array controls decoded from the registered state.
  always_comb begin
    bus.cmd_ready     = (state == IDLE);
    bus.busy          = (state != IDLE);
    bus.mac_clear_acc = (state == CLEAR);
    bus.opd_ready     = (state == ACCUM);
    bus.mac_enable    = (state == ACCUM) && bus.opd_valid && !bus.abort;
    bus.res_valid     = (state == DONE);
    bus.mac_data_type = dtype_q;
    bus.aborted       = aborted_q;
    bus.stall_cnt     = stall_q;
  end

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Bench for mac_tile_sequencer: table of tiles checked through a scoreboard,
// plus hand-written abort and async-reset sequences.
module tb_mac_tile_sequencer;
  localparam int K_W     = 16;
  localparam int DRAIN   = 5;
  localparam int STALL_W = 4;   // narrow so saturation is reachable

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_tile_sequencer_if #(.K_W(K_W), .STALL_W(STALL_W)) bus ();

  mac_tile_sequencer #(.K_W(K_W), .DRAIN_CYCLES(DRAIN), .STALL_W(STALL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          k;
    logic        dt;
    logic [63:0] mask;      // bit c set: opd_valid low in cycle c after accept
    int          hold;      // DONE cycles with res_ready low
    int          exp_en;
    int          exp_stall;
    int          exp_resv;  // cycle of first res_valid, accept = cycle 0
    int          exp_len;
    int          exp_ordy;
  } vec_t;

  typedef struct {
    int   en;
    int   stall;
    int   resv;
    int   len;
    int   ordy;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input vec_t v, input int idx);
    exp_t e;
    int en = 0, clr_n = 0, clr_cyc = -1, resv_cyc = -1, len = 0, ordy = 0, done_seen = 0;
    bit hs = 0, finished = 0, dt_bad = 0, rdy_bad = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    sb.push_back('{v.exp_en, v.exp_stall, v.exp_resv, v.exp_len, v.exp_ordy});
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      // Junk commands are held valid throughout the tile to prove they are ignored.
      bus.cmd_valid     = (cyc == 0) || !hs;
      bus.cmd_k_len     = (cyc == 0) ? K_W'(v.k) : K_W'(7);
      bus.cmd_data_type = (cyc == 0) ? v.dt : ~v.dt;
      bus.opd_valid     = (cyc < 64) ? !v.mask[cyc] : 1'b1;
      bus.res_ready     = (done_seen >= v.hold);
      @(negedge clk);
      if (hs) begin
        chk({tag, "_ready_after"}, bus.cmd_ready, 1);
        chk({tag, "_busy_after"}, bus.busy, 0);
        finished = 1;
      end else begin
        if (cyc == 0) chk({tag, "_ready_accept"}, bus.cmd_ready, 1);
        else if (bus.cmd_ready) rdy_bad = 1;
        if (bus.mac_enable) begin
          en++;
          if (bus.mac_data_type !== v.dt || !bus.opd_valid) dt_bad = 1;
        end
        if (bus.mac_clear_acc) begin
          clr_n++;
          if (clr_cyc < 0) clr_cyc = cyc;
        end
        if (bus.opd_ready) ordy++;
        if (bus.res_valid) begin
          if (resv_cyc < 0) resv_cyc = cyc;
          len++;
          done_seen++;
          if (bus.res_ready) hs = 1;
        end
      end
      next_cyc();
    end
    if (!finished) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_enables"}, en, e.en);
      chk({tag, "_stall_cnt"}, bus.stall_cnt, e.stall);
      chk({tag, "_res_valid_cyc"}, resv_cyc, e.resv);
      chk({tag, "_res_valid_len"}, len, e.len);
      chk({tag, "_opd_ready_cycles"}, ordy, e.ordy);
      chk({tag, "_clear_cyc"}, clr_cyc, 1);
      chk({tag, "_clear_count"}, clr_n, 1);
      chk({tag, "_enable_dtype"}, dt_bad, 0);
      chk({tag, "_ready_while_busy"}, rdy_bad, 0);
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    // k, dt, mask, hold, en, stall, resv, len, ordy
    vecs[0] = '{4, 1'b0, 64'h0,      0, 4, 0,  11, 1, 4};
    vecs[1] = '{3, 1'b1, 64'h28,     0, 3, 2,  12, 1, 5};
    vecs[2] = '{0, 1'b0, 64'h0,      0, 0, 0,   7, 1, 0};
    vecs[3] = '{2, 1'b0, 64'h0,      4, 2, 0,   9, 5, 2};
    vecs[4] = '{1, 1'b1, 64'h0,      0, 1, 0,   8, 1, 1};
    vecs[5] = '{5, 1'b0, 64'h1C,     0, 5, 3,  15, 1, 8};
    vecs[6] = '{1, 1'b1, 64'h3FFFFC, 0, 1, 15, 28, 1, 21};

    bus.cmd_valid = 1'b0; bus.cmd_k_len = '0; bus.cmd_data_type = 1'b1;
    bus.abort = 1'b0; bus.opd_valid = 1'b1; bus.res_ready = 1'b0;

    // Reset values.
    #12;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_opd_ready", bus.opd_ready, 0);
    chk("rst_mac_enable", bus.mac_enable, 0);
    chk("rst_clear_acc", bus.mac_clear_acc, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_aborted", bus.aborted, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_data_type", bus.mac_data_type, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();

    for (int i = 0; i < 7; i++) run_tile(vecs[i], i);

    // Abort in IDLE does nothing.
    bus.abort = 1'b1;
    next_cyc();
    bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_pulse", bus.aborted, 0);
    chk("idle_abort_ready", bus.cmd_ready, 1);
    next_cyc();

    // Abort on the 2nd ACCUM beat of a k=8 tile, then immediate new command.
    bus.cmd_valid = 1'b1; bus.cmd_k_len = 16'd8; bus.cmd_data_type = 1'b0;
    bus.opd_valid = 1'b1; bus.res_ready = 1'b1;
    next_cyc();                        // cyc1 CLEAR
    bus.cmd_valid = 1'b0;
    next_cyc();                        // cyc2 beat 1
    next_cyc();                        // cyc3 beat 2 + abort
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_enable_forced", bus.mac_enable, 0);
    chk("abort_opd_ready", bus.opd_ready, 1);
    next_cyc();                        // cyc4 IDLE
    bus.abort = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_k_len = 16'd1;
    @(negedge clk);
    chk("abort_pulse", bus.aborted, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_res_valid", bus.res_valid, 0);
    next_cyc();                        // cyc5 CLEAR of new tile
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_pulse_one_cycle", bus.aborted, 0);
    chk("abort_new_cmd_clear", bus.mac_clear_acc, 1);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      next_cyc();
      @(negedge clk);
      if (bus.res_valid) seen = 1;
    end
    chk("abort_new_tile_result", seen, 1);
    next_cyc();
    next_cyc();

    // Async reset mid-DRAIN: k=2 with one stall at cycle 2, DRAIN spans cycles 5-9.
    bus.cmd_valid = 1'b1; bus.cmd_k_len = 16'd2; bus.cmd_data_type = 1'b1;
    bus.res_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cyc();
      bus.cmd_valid = 1'b0;
      bus.opd_valid = (c != 2);
    end
    @(negedge clk);
    chk("drain_busy", bus.busy, 1);
    chk("drain_stall_cnt", bus.stall_cnt, 1);
    chk("drain_cmd_ready", bus.cmd_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_stall_cnt", bus.stall_cnt, 0);
    chk("arst_data_type", bus.mac_data_type, 0);
    chk("arst_res_valid", bus.res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    chk("arst_no_abort_pulse", bus.aborted, 0);
    chk("arst_idle", bus.cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
